mem_arbiter: RTL and testbench

Sequential arbiter sharing the single RAM port between the instruction-fetch path and the data-memory path of the pipelined datapath. Each requester holds a request until its wait signal drops. The RAM is granted to one requester at a time through a registered grant FSM. Data accesses have priority, bounded by a starvation limit that guarantees instruction fetch progress. The block sits between the datapath (which drives ihit/dhit to the hazard unit from iwait/dwait) and the RAM model.

---
 rtl/mem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single RAM port between the instruction-fetch path and the
// data-memory path. The grant FSM is IDLE -> IGNT/DGNT -> IDLE, so there is
// always one IDLE bubble between two grants. Data accesses win arbitration
// unless instruction fetch has been passed over STARVE_LIMIT times in a row
// while it was pending.
//
// Parameters
//   STARVE_LIMIT  consecutive data grants allowed while i_iren is pending
//                 before the fetch is forced a grant (1..15)
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous, active-low reset
//   i_iren        instruction read request (held until o_iwait is low)
//   i_iaddr       instruction word address
//   i_dren        data read request  (held until o_dwait is low)
//   i_dwen        data write request (held until o_dwait is low)
//   i_daddr       data address
//   i_dstore      data write value
//   i_ramstate    RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
//   i_ramload     RAM read data
//   o_iwait       low only in the cycle the instruction access completes
//   o_dwait       low only in the cycle the data access completes
//   o_iload       RAM read data towards the fetch path
//   o_dload       RAM read data towards the data path
//   o_ramren      RAM read strobe
//   o_ramwen      RAM write strobe
//   o_ramaddr     RAM address
//   o_ramstore    RAM write data
//   o_merr        sticky RAM error flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_iren,
    input  logic [31:0] i_iaddr,
    input  logic        i_dren,
    input  logic        i_dwen,
    input  logic [31:0] i_daddr,
    input  logic [31:0] i_dstore,
    input  logic [1:0]  i_ramstate,
    input  logic [31:0] i_ramload,
    output logic        o_iwait,
    output logic        o_dwait,
    output logic [31:0] o_iload,
    output logic [31:0] o_dload,
    output logic        o_ramren,
    output logic        o_ramwen,
    output logic [31:0] o_ramaddr,
    output logic [31:0] o_ramstore,
    output logic        o_merr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IGNT = 2'd1,
        ST_DGNT = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
    localparam logic [3:0] SCNT_MAX   = 4'd15;

    state_t     r_state;
    logic [3:0] r_scnt;
    logic       r_merr;

    logic w_dreq;
    logic w_ram_access;
    logic w_ram_error;
    logic w_pick_data;

    assign w_dreq       = i_dren | i_dwen;
    assign w_ram_access = (i_ramstate == RAM_ACCESS);
    assign w_ram_error  = (i_ramstate == RAM_ERROR);

    // Data wins unless the fetch is both waiting and already starved.
    assign w_pick_data  = w_dreq && (!i_iren || (r_scnt < STARVE_LIM));

    // -------------------------------------------------------------------------
    // Grant FSM, starve counter and sticky error flag
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_scnt  <= 4'd0;
            r_merr  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_data) begin
                        r_state <= ST_DGNT;
                    end else if (i_iren) begin
                        r_state <= ST_IGNT;
                    end
                    // Fetch not waiting: nothing is being starved.
                    if (!i_iren) begin
                        r_scnt <= 4'd0;
                    end
                end

                ST_IGNT: begin
                    // Abort takes precedence: no access is in flight once
                    // the requester has withdrawn.
                    if (!i_iren) begin
                        r_state <= ST_IDLE;
                    end else if (w_ram_error) begin
                        r_merr  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (w_ram_access) begin
                        r_scnt  <= 4'd0;
                        r_state <= ST_IDLE;
                    end
                end

                ST_DGNT: begin
                    if (!w_dreq) begin
                        r_state <= ST_IDLE;
                    end else if (w_ram_error) begin
                        r_merr  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (w_ram_access) begin
                        // Only a completed data access while the fetch waits
                        // counts towards starvation.
                        if (i_iren && (r_scnt != SCNT_MAX)) begin
                            r_scnt <= r_scnt + 4'd1;
                        end
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // RAM port and wait decode. Waits must drop in the same cycle the RAM
    // reports ACCESS, so this path is combinational from state and inputs.
    // -------------------------------------------------------------------------
    always_comb begin
        o_ramren   = 1'b0;
        o_ramwen   = 1'b0;
        o_ramaddr  = 32'd0;
        o_ramstore = 32'd0;
        o_iwait    = 1'b1;
        o_dwait    = 1'b1;

        case (r_state)
            ST_IGNT: begin
                o_ramaddr = i_iaddr;
                if (i_iren) begin
                    o_ramren = 1'b1;
                    if (w_ram_access) begin
                        o_iwait = 1'b0;
                    end
                end
            end

            ST_DGNT: begin
                o_ramaddr  = i_daddr;
                o_ramstore = i_dstore;
                if (w_dreq) begin
                    // A write wins when both strobes are requested.
                    o_ramwen = i_dwen;
                    o_ramren = i_dren & ~i_dwen;
                    if (w_ram_access) begin
                        o_dwait = 1'b0;
                    end
                end
            end

            default: begin
            end
        endcase
    end

    assign o_iload = i_ramload;
    assign o_dload = i_ramload;
    assign o_merr  = r_merr;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. A small RAM model answers strobes after a
// programmable number of BUSY cycles (or with ERROR). Expected completions
// are queued as requests are driven and popped whenever a wait drops.
// All DUT sampling happens 1 time unit after the rising edge, before any
// input is changed in that cycle.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam logic [1:0] RAM_FREE   = 2'd0;
    localparam logic [1:0] RAM_BUSY   = 2'd1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam int K_IREAD  = 0;
    localparam int K_DREAD  = 1;
    localparam int K_DWRITE = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iren;
    logic [31:0] iaddr;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [1:0]  ramstate;
    logic [31:0] ramload;
    logic        iwait;
    logic        dwait;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        ramren;
    logic        ramwen;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic        merr;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_iren     (iren),
        .i_iaddr    (iaddr),
        .i_dren     (dren),
        .i_dwen     (dwen),
        .i_daddr    (daddr),
        .i_dstore   (dstore),
        .i_ramstate (ramstate),
        .i_ramload  (ramload),
        .o_iwait    (iwait),
        .o_dwait    (dwait),
        .o_iload    (iload),
        .o_dload    (dload),
        .o_ramren   (ramren),
        .o_ramwen   (ramwen),
        .o_ramaddr  (ramaddr),
        .o_ramstore (ramstore),
        .o_merr     (merr)
    );

    always #5 clk = ~clk;

    // ---------------- RAM model ----------------
    int   ram_lat = 0;
    logic ram_err = 1'b0;
    int   bcnt    = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    always @(posedge clk) begin
        if ((ramren || ramwen) && ramstate != RAM_ACCESS) bcnt <= bcnt + 1;
        else                                               bcnt <= 0;
    end

    always_comb begin
        ramstate = RAM_FREE;
        if (ramren || ramwen) begin
            if (ram_err)              ramstate = RAM_ERROR;
            else if (bcnt >= ram_lat) ramstate = RAM_ACCESS;
            else                      ramstate = RAM_BUSY;
        end
    end

    assign ramload = memf(ramaddr);

    // ---------------- scoreboard ----------------
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn_no = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] addr, input logic [31:0] data);
        txn_t t;
        t.kind = kind;
        t.addr = addr;
        t.data = data;
        exp_q.push_back(t);
    endtask

    task automatic monitor();
        txn_t        e;
        int          kind;
        logic [31:0] dat;
        if (!iwait || !dwait) begin
            check("single_wait_low", 32'(iwait | dwait), 32'd1);
            kind = !iwait ? K_IREAD : (ramwen ? K_DWRITE : K_DREAD);
            dat  = (kind == K_IREAD) ? iload : ((kind == K_DREAD) ? dload : ramstore);
            txn_no++;
            $display("txn %0d: kind=%0d addr=%08h data=%08h t=%0t", txn_no, kind, ramaddr, dat, $time);
            check("completion_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("txn_kind", 32'(kind), 32'(e.kind));
                check("txn_addr", ramaddr, e.addr);
                check("txn_data", dat, e.data);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic drain(input int max_cycles, output int n);
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            cyc();
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // ---- reset with a fetch pending ----
        rst_n  = 1'b0;
        iren   = 1'b1;
        iaddr  = 32'h40;
        dren   = 1'b0;
        dwen   = 1'b0;
        daddr  = 32'h0;
        dstore = 32'h0;
        cyc();
        cyc();
        check("rst_iwait",    32'(iwait),  32'd1);
        check("rst_dwait",    32'(dwait),  32'd1);
        check("rst_ramren",   32'(ramren), 32'd0);
        check("rst_ramwen",   32'(ramwen), 32'd0);
        check("rst_ramaddr",  ramaddr,     32'h0);
        check("rst_ramstore", ramstore,    32'h0);
        check("rst_merr",     32'(merr),   32'd0);
        check("rst_iload",    iload,       32'h0000FFFF);

        // ---- release: fetch granted next edge, zero-wait RAM ----
        push(K_IREAD, 32'h40, memf(32'h40));
        rst_n = 1'b1;
        cyc();
        check("fetch_ramren",  32'(ramren), 32'd1);
        check("fetch_ramaddr", ramaddr,     32'h40);
        check("fetch_iwait",   32'(iwait),  32'd0);
        cyc();
        check("fetch_idle_ren",   32'(ramren), 32'd0);
        check("fetch_idle_iwait", 32'(iwait),  32'd1);
        iren = 1'b0;
        cyc();
        check("idle_ren", 32'(ramren), 32'd0);
        check("q_after_fetch", 32'(exp_q.size()), 32'd0);

        // ---- write priority over pending fetch ----
        iren   = 1'b1;
        iaddr  = 32'h80;
        dren   = 1'b1;
        dwen   = 1'b1;
        daddr  = 32'h100;
        dstore = 32'hDEADBEEF;
        push(K_DWRITE, 32'h100, 32'hDEADBEEF);
        push(K_IREAD,  32'h80,  memf(32'h80));
        cyc();
        check("wr_ramwen",   32'(ramwen), 32'd1);
        check("wr_ramren",   32'(ramren), 32'd0);
        check("wr_ramstore", ramstore,    32'hDEADBEEF);
        check("wr_iwait",    32'(iwait),  32'd1);
        cyc();
        dren = 1'b0;
        dwen = 1'b0;
        cyc();
        check("wr_then_fetch_ren", 32'(ramren), 32'd1);
        check("wr_then_fetch_q",   32'(exp_q.size()), 32'd0);
        cyc();
        iren = 1'b0;
        cyc();

        // ---- starvation: 4 data grants, then a fetch, then data resumes ----
        iren  = 1'b1;
        iaddr = 32'h200;
        dren  = 1'b1;
        daddr = 32'h300;
        for (int i = 0; i < 4; i++) push(K_DREAD, 32'h300, memf(32'h300));
        push(K_IREAD, 32'h200, memf(32'h200));
        for (int i = 0; i < 2; i++) push(K_DREAD, 32'h300, memf(32'h300));
        drain(40, n);
        check("starve_cycles", 32'(n), 32'd13);
        cyc();
        iren = 1'b0;
        dren = 1'b0;
        cyc();

        // ---- multi-cycle RAM: 2 BUSY cycles then ACCESS ----
        ram_lat = 2;
        dren    = 1'b1;
        daddr   = 32'h500;
        push(K_DREAD, 32'h500, memf(32'h500));
        drain(10, n);
        check("busy_latency", 32'(n), 32'd3);
        cyc();
        dren    = 1'b0;
        ram_lat = 0;
        cyc();

        // ---- RAM error during a data grant, then retry ----
        ram_err = 1'b1;
        dren    = 1'b1;
        daddr   = 32'h600;
        cyc();
        check("err_dwait", 32'(dwait), 32'd1);
        cyc();
        check("err_merr",       32'(merr),   32'd1);
        check("err_idle_ren",   32'(ramren), 32'd0);
        check("err_idle_dwait", 32'(dwait),  32'd1);
        ram_err = 1'b0;
        push(K_DREAD, 32'h600, memf(32'h600));
        drain(4, n);
        check("err_retry_cycles", 32'(n), 32'd1);
        cyc();
        dren = 1'b0;
        cyc();
        check("merr_sticky", 32'(merr), 32'd1);

        // ---- fetch abort while RAM is busy ----
        ram_lat = 3;
        iren    = 1'b1;
        iaddr   = 32'h700;
        cyc();
        check("abort_ren_before",  32'(ramren), 32'd1);
        check("abort_addr_before", ramaddr,     32'h700);
        cyc();
        iren = 1'b0;
        #1;
        check("abort_ren",   32'(ramren), 32'd0);
        check("abort_iwait", 32'(iwait),  32'd1);
        cyc();
        check("abort_idle_ren",   32'(ramren), 32'd0);
        check("abort_idle_iwait", 32'(iwait),  32'd1);

        // ---- reset asserted during a busy data write ----
        ram_lat = 5;
        dwen    = 1'b1;
        daddr   = 32'h800;
        dstore  = 32'h12345678;
        cyc();
        check("mrst_wen_before",   32'(ramwen), 32'd1);
        check("mrst_store_before", ramstore,    32'h12345678);
        cyc();
        rst_n = 1'b0;
        #1;
        check("mrst_wen",   32'(ramwen), 32'd0);
        check("mrst_ren",   32'(ramren), 32'd0);
        check("mrst_dwait", 32'(dwait),  32'd1);
        check("mrst_merr",  32'(merr),   32'd0);
        check("mrst_addr",  ramaddr,     32'h0);
        dwen = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        check("post_rst_wen",   32'(ramwen), 32'd0);
        check("post_rst_dwait", 32'(dwait),  32'd1);
        check("final_q_empty",  32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
